// File: rtl/clken_pkg.sv
// clken_pkg: shared FSM state encoding and counter-width helper for clken_gen
package clken_pkg;
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_t;
  function automatic int cnt_width(input int lock_wait);
    return $clog2(lock_wait + 1);
  endfunction
endpackage

// File: rtl/clken_phase_acc.sv
// clken_phase_acc: one fractional-rate channel, phase accumulator with registered carry and ce
// Ports: clock, reset (sync, active-high), run (accumulate when high), inc (phase step), ce (one-cycle strobe)
module clken_phase_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [ACC_W-1:0] inc,
  output logic             ce
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic carry_q, carry_d, ce_q, ce_d;
  always_comb begin
    {carry_d, acc_d} = run ? {1'b0, acc_q} + {1'b0, inc} : '0;
    ce_d = run & carry_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      ce_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ce_q    <= ce_d;
    end
  end
  assign ce = ce_q;
endmodule

// File: rtl/clken_gen.sv
// clken_gen: PLL-lock reset sequencer plus NCH phase-accumulator clock-enable strobes
// Ports: clock, reset (sync, active-high), pll_locked (async), inc_wr/inc_sel/inc_data (increment writes),
//        rst_out, ready, ce[NCH], lock_lost. Define CLKEN_LOSS_DETECT_EN to return to HOLD on lock loss in RUN.
module clken_gen
  import clken_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int ACC_W     = 24,
  parameter int LOCK_WAIT = 1024,
  localparam int SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             inc_wr,
  input  logic [SEL_W-1:0] inc_sel,
  input  logic [ACC_W-1:0] inc_data,
  output logic             rst_out,
  output logic             ready,
  output logic [NCH-1:0]   ce,
  output logic             lock_lost
);
  localparam int CNT_W = cnt_width(LOCK_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic s1_q, s2_q, rst_out_q, rst_out_d, ready_q, ready_d, lock_lost_q, lock_lost_d, loss, run;
  logic [ACC_W-1:0] inc_q [NCH];
  logic [ACC_W-1:0] inc_d [NCH];
`ifdef CLKEN_LOSS_DETECT_EN
  assign loss = (state_q == RUN) && !s2_q;
`else
  assign loss = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HOLD: if (s2_q) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (!s2_q) state_d = HOLD;
            else if (cnt_q == CNT_LAST) state_d = RUN;
            else cnt_d = cnt_q + CNT_W'(1);
      RUN:  if (loss) state_d = HOLD;
      default: state_d = HOLD;
    endcase
    rst_out_d   = state_d != RUN;
    ready_d     = state_d == RUN;
    lock_lost_d = lock_lost_q | loss;
    inc_d = inc_q;
    // Select values with no channel behind them match nothing and are dropped.
    for (int i = 0; i < NCH; i++)
      if (inc_wr && inc_sel == SEL_W'(i)) inc_d[i] = inc_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      rst_out_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      inc_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_q        <= pll_locked;
      s2_q        <= s1_q;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      inc_q       <= inc_d;
    end
  end
  assign run = state_q == RUN;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    clken_phase_acc #(.ACC_W(ACC_W)) u_acc (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .inc   (inc_q[c]),
      .ce    (ce[c])
    );
  end
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
endmodule

// File: tb/tb_clken_gen.sv
// tb_clken_gen: directed/random bench for clken_gen with a total-phase reference model
module tb_clken_gen;
  localparam int NCH = 2, ACC_W = 8, LW = 16;
  logic clock = 1'b0, reset = 1'b1, pll_locked = 1'b0, inc_wr = 1'b0;
  logic [0:0] inc_sel = 1'b0;
  logic [ACC_W-1:0] inc_data = '0;
  logic rst_out, ready, lock_lost;
  logic [NCH-1:0] ce;

  clken_gen #(.NCH(NCH), .ACC_W(ACC_W), .LOCK_WAIT(LW)) dut (
    .clock      (clock),
    .reset      (reset),
    .pll_locked (pll_locked),
    .inc_wr     (inc_wr),
    .inc_sel    (inc_sel),
    .inc_data   (inc_data),
    .rst_out    (rst_out),
    .ready      (ready),
    .ce         (ce),
    .lock_lost  (lock_lost)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0, cyc = 0;
  // Model: total phase added since RUN began; a strobe is due whenever the
  // integer number of 2^ACC_W wraps grows, and shows up one edge later on ce.
  bit     m_run = 1'b0;
  int     m_inc [NCH];
  longint tot [NCH];
  int     pend [NCH];
  int     ce_exp [NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    for (int c = 0; c < NCH; c++) begin
      if (reset || !m_run) begin
        tot[c] = 0; pend[c] = 0; ce_exp[c] = 0;
      end else begin
        ce_exp[c] = pend[c];
        pend[c]   = int'((tot[c] + longint'(m_inc[c])) / 256 - tot[c] / 256);
        tot[c]    = tot[c] + longint'(m_inc[c]);
      end
    end
    if (reset) begin
      m_run = 1'b0;
      for (int c = 0; c < NCH; c++) m_inc[c] = 0;
    end else if (inc_wr) m_inc[inc_sel] = int'(inc_data);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) check($sformatf("ce%0d", c), 32'(ce[c]), 32'(ce_exp[c]));
  endtask

  // Lock is already high; the first tick is the edge that samples it.
  task automatic release_check(input string tag);
    for (int k = 0; k <= LW + 2; k++) begin
      tick();
      check({tag, "_rst"}, 32'(rst_out), 32'(k < LW + 2));
      check({tag, "_rdy"}, 32'(ready), 32'(k == LW + 2));
    end
    m_run = 1'b1;
  endtask

  // Expects inc = 128/85 and a settled accumulator.
  task automatic window_check(input string tag);
    int c0 = 0, c1 = 0, a0 = 0, a1 = 0;
    logic p0, p1;
    p0 = ce[0];
    p1 = ce[1];
    for (int n = 0; n < 256; n++) begin
      tick();
      check({tag, "_alt0"}, 32'(ce[0]), 32'(!p0));
      check({tag, "_wid1"}, 32'(ce[1] && p1), 32'd0);
      p0 = ce[0]; p1 = ce[1];
      c0 += int'(ce[0]); c1 += int'(ce[1]);
      if (n == 99) begin a0 = c0; a1 = c1; end
    end
    check({tag, "_ce0_100"}, 32'(a0), 32'd50);
    check({tag, "_ce1_100"}, 32'(a1 == 33 || a1 == 34), 32'd1);
    check({tag, "_ce0_256"}, 32'(c0), 32'd128);
    check({tag, "_ce1_256"}, 32'(c1), 32'd85);
  endtask

  task automatic write_inc(input int sel, input int val);
    inc_wr = 1'b1; inc_sel = 1'(sel); inc_data = ACC_W'(val);
    tick();
    inc_wr = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (3) tick();
    check("rst_rst", 32'(rst_out), 32'd1);
    check("rst_rdy", 32'(ready), 32'd0);
    check("rst_ll", 32'(lock_lost), 32'd0);
    reset = 1'b0;
    repeat ($urandom_range(2, 6)) tick();
    check("hold_rdy", 32'(ready), 32'd0);
    pll_locked = 1'b1;
    release_check("rel1");

    // Restart, then drop lock for one sampled edge while cnt = 10.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      tick();
      check("drop_rdy", 32'(ready), 32'd0);
    end
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    release_check("rel2");

    write_inc(0, 128);
    write_inc(1, 85);
    repeat (4) tick();
    window_check("run");

    // At NCH = 2 every select value is a real channel, so the nearest
    // no-side-effect case is data and select wiggling without a strobe.
    inc_sel = 1'b1; inc_data = 8'hFF;
    repeat (3) tick();
    inc_sel = 1'b0;
    window_check("nowr");

    for (int r = 0; r < 3; r++) begin
      write_inc(0, int'($urandom_range(0, 255)));
      write_inc(1, int'($urandom_range(0, 255)));
      repeat (200) tick();
    end
    write_inc(0, 0);
    write_inc(1, 0);
    repeat (3) tick();
    write_inc(0, 128);
    write_inc(1, 85);
    repeat (4) tick();

`ifdef CLKEN_LOSS_DETECT_EN
    pll_locked = 1'b0;
    tick();
    check("loss_rdy0", 32'(ready), 32'd1);
    tick();
    check("loss_rdy1", 32'(ready), 32'd1);
    check("loss_ll1", 32'(lock_lost), 32'd0);
    tick();
    check("loss_rst", 32'(rst_out), 32'd1);
    check("loss_rdy2", 32'(ready), 32'd0);
    check("loss_ll2", 32'(lock_lost), 32'd1);
    m_run = 1'b0;
    pll_locked = 1'b1;
    release_check("rel3");
    check("relock_ll", 32'(lock_lost), 32'd1);
    repeat (4) tick();
    window_check("relock");
    check("relock_ll2", 32'(lock_lost), 32'd1);
`else
    pll_locked = 1'b0;
    repeat (6) tick();
    check("noloss_rdy", 32'(ready), 32'd1);
    check("noloss_rst", 32'(rst_out), 32'd0);
    check("noloss_ll", 32'(lock_lost), 32'd0);
    pll_locked = 1'b1;
    repeat (3) tick();
    window_check("noloss");
`endif

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_rst", 32'(rst_out), 32'd1);
    check("midrst_rdy", 32'(ready), 32'd0);
    check("midrst_ce", 32'(ce), 32'd0);
    check("midrst_ll", 32'(lock_lost), 32'd0);
    release_check("rel4");
    cnt = 0;
    repeat (60) begin
      tick();
      cnt += int'(ce[0]) + int'(ce[1]);
    end
    check("midrst_inc0", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
